// File: rtl/asym_capture_pkg.sv
// Shared types and helpers for the asymmetric capture buffer.
package asym_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } cap_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/asym_capture_ram_core.sv
// Single-clock asymmetric storage: narrow write port, wide read-first read port.
// ASYM_CAPTURE_RAM_OUTREG_EN adds a second output register (read latency 2).
module asym_capture_ram_core
    import asym_capture_pkg::*;
#(
    parameter int unsigned DATAWIDTHA = 32,
    parameter int unsigned DATAWIDTHB = 512,
    parameter int unsigned DEPTHA     = 16384,
    parameter logic [31:0] INIT_WORD  = 32'h7fff0000,
    parameter string       RAM_STYLE  = "block",
    localparam int unsigned RATIO      = DATAWIDTHB / DATAWIDTHA,
    localparam int unsigned ADDRWIDTHA = clog2(DEPTHA),
    localparam int unsigned DEPTHB     = DEPTHA / RATIO,
    localparam int unsigned ADDRWIDTHB = clog2(DEPTHB)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDRWIDTHA-1:0] i_waddr,
    input  logic [DATAWIDTHA-1:0] i_wdata,
    input  logic                  i_ren,
    input  logic [ADDRWIDTHB-1:0] i_raddr,
    output logic [DATAWIDTHB-1:0] o_dout,
    output logic                  o_dout_valid
);

    localparam logic [DATAWIDTHA-1:0] InitA = DATAWIDTHA'(INIT_WORD);

    (* ram_style = RAM_STYLE *)
    logic [DATAWIDTHA-1:0] r_mem [DEPTHA] = '{default: InitA};

    logic [DATAWIDTHB-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Lane i of the wide word maps to narrow address raddr*RATIO + i, lane 0 in the LSBs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_ren;
            if (i_ren) begin
                for (int lane = 0; lane < int'(RATIO); lane++) begin
                    r_rd_data[lane*DATAWIDTHA +: DATAWIDTHA] <=
                        r_mem[ADDRWIDTHA'(int'(i_raddr) * int'(RATIO) + lane)];
                end
            end
        end
    end

`ifdef ASYM_CAPTURE_RAM_OUTREG_EN
    logic [DATAWIDTHB-1:0] r_out_data;
    logic                  r_out_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_rd_valid;
            if (r_rd_valid) begin
                r_out_data <= r_rd_data;
            end
        end
    end

    assign o_dout       = r_out_data;
    assign o_dout_valid = r_out_valid;
`else
    assign o_dout       = r_rd_data;
    assign o_dout_valid = r_rd_valid;
`endif

endmodule

// File: rtl/asym_capture_ram.sv
// Capture buffer: narrow samples written at an auto-incrementing pointer under arm/stop,
// read back as wide words. ASYM_CAPTURE_RAM_OUTREG_EN selects the registered-output core.
module asym_capture_ram
    import asym_capture_pkg::*;
#(
    parameter int unsigned DATAWIDTHA = 32,
    parameter int unsigned DATAWIDTHB = 512,
    parameter int unsigned DEPTHA     = 16384,
    parameter logic [31:0] INIT_WORD  = 32'h7fff0000,
    parameter string       RAM_STYLE  = "block",
    localparam int unsigned RATIO      = DATAWIDTHB / DATAWIDTHA,
    localparam int unsigned ADDRWIDTHA = clog2(DEPTHA),
    localparam int unsigned DEPTHB     = DEPTHA / RATIO,
    localparam int unsigned ADDRWIDTHB = clog2(DEPTHB)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_arm,
    input  logic                  i_stop,
    input  logic                  i_mode_circ,
    input  logic [ADDRWIDTHA:0]   i_len,
    input  logic [DATAWIDTHA-1:0] i_din,
    input  logic                  i_din_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wrapped,
    output logic [ADDRWIDTHA-1:0] o_wr_ptr,
    output logic [ADDRWIDTHA:0]   o_wr_count,
    input  logic [ADDRWIDTHB-1:0] i_raddr,
    input  logic                  i_ren,
    output logic [DATAWIDTHB-1:0] o_dout,
    output logic                  o_dout_valid
);

    localparam int unsigned LenW = ADDRWIDTHA + 1;

    cap_state_e            r_state;
    logic                  r_circ;
    logic [LenW-1:0]       r_len;
    logic [ADDRWIDTHA-1:0] r_wr_ptr;
    logic [LenW-1:0]       r_wr_count;
    logic                  r_wrapped;
    logic                  r_busy;
    logic                  r_done;

    logic [LenW-1:0]       w_len_eff;
    logic [LenW-1:0]       w_count_inc;
    logic                  w_ptr_last;
    logic                  w_we;

    always_comb begin
        w_len_eff = i_len;
        if (i_len == '0 || i_len > LenW'(DEPTHA)) begin
            w_len_eff = LenW'(DEPTHA);
        end
    end

    assign w_count_inc = (r_wr_count == r_len) ? r_wr_count : r_wr_count + LenW'(1);
    assign w_ptr_last  = ({1'b0, r_wr_ptr} == r_len - LenW'(1));
    // Arm on a capture cycle restarts instead of writing; reset drops the write.
    assign w_we        = (r_state == StCapture) && i_din_valid && !i_arm && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_circ     <= 1'b0;
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_wrapped  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (i_arm) begin
            r_state    <= StCapture;
            r_circ     <= i_mode_circ;
            r_len      <= w_len_eff;
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_wrapped  <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                StCapture: begin
                    if (i_din_valid) begin
                        r_wr_count <= w_count_inc;
                        if (r_circ && w_ptr_last) begin
                            r_wr_ptr  <= '0;
                            r_wrapped <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + ADDRWIDTHA'(1);
                        end
                        if (!r_circ && w_count_inc == r_len) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    if (r_circ && i_stop) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_wrapped  = r_wrapped;
    assign o_wr_ptr   = r_wr_ptr;
    assign o_wr_count = r_wr_count;

    asym_capture_ram_core #(
        .DATAWIDTHA (DATAWIDTHA),
        .DATAWIDTHB (DATAWIDTHB),
        .DEPTHA     (DEPTHA),
        .INIT_WORD  (INIT_WORD),
        .RAM_STYLE  (RAM_STYLE)
    ) u_core (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_we         (w_we),
        .i_waddr      (r_wr_ptr),
        .i_wdata      (i_din),
        .i_ren        (i_ren),
        .i_raddr      (i_raddr),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid)
    );

endmodule

// File: tb/tb_asym_capture_ram.sv
// Randomised scoreboard bench for asym_capture_ram with a behavioural capture model.
module tb_asym_capture_ram;

    localparam int unsigned DW_A   = 32;
    localparam int unsigned DW_B   = 512;
    localparam int unsigned DEPTH  = 16384;
    localparam int unsigned RATIO  = DW_B / DW_A;
    localparam logic [31:0] INIT   = 32'h7fff0000;
`ifdef ASYM_CAPTURE_RAM_OUTREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic              mode_circ = 1'b0;
    logic [14:0]       len = '0;
    logic [31:0]       din = '0;
    logic              din_valid = 1'b0;
    logic              busy, done, wrapped;
    logic [13:0]       wr_ptr;
    logic [14:0]       wr_count;
    logic [9:0]        raddr = '0;
    logic              ren = 1'b0;
    logic [DW_B-1:0]   dout;
    logic              dout_valid;

    asym_capture_ram dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_arm        (arm),
        .i_stop       (stop),
        .i_mode_circ  (mode_circ),
        .i_len        (len),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_busy       (busy),
        .o_done       (done),
        .o_wrapped    (wrapped),
        .o_wr_ptr     (wr_ptr),
        .o_wr_count   (wr_count),
        .i_raddr      (raddr),
        .i_ren        (ren),
        .o_dout       (dout),
        .o_dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: memory image plus capture status.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy, m_done, m_wrapped, m_circ;
    int unsigned m_ptr, m_count, m_len;

    typedef struct {
        logic [DW_B-1:0] data;
        int unsigned     cyc;
    } rd_t;
    rd_t rd_q[$];

    logic [DW_B-1:0] last_dout = '0;
    bit              mon_en = 1'b0;

    always @(negedge clk) begin
        rd_t e;
        if (mon_en) begin
            if (dout_valid) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_unexpected: dout_valid=1 with no read outstanding");
                end else begin
                    e = rd_q.pop_front();
                    if (dout !== e.data || cyc - e.cyc != LAT - 1) begin
                        n_fail++;
                        $display("FAIL read_data: got %h lat %0d, expected %h lat %0d",
                                 dout, cyc - e.cyc + 1, e.data, LAT);
                    end
                end
            end else begin
                n_cmp++;
                if (dout !== last_dout) begin
                    n_fail++;
                    $display("FAIL dout_hold: got %h expected %h", dout, last_dout);
                end
            end
        end
        last_dout = dout;
        if (rst) last_dout = '0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit a, input bit s, input bit c, input int unsigned ln,
                        input logic [31:0] d, input bit dv, input bit rd,
                        input int unsigned ra, input bit rs);
        rd_t e;
        arm = a; stop = s; mode_circ = c; len = 15'(ln);
        din = d; din_valid = dv; ren = rd; raddr = 10'(ra); rst = rs;
        if (rd && !rs) begin
            for (int i = 0; i < int'(RATIO); i++) begin
                e.data[i*DW_A +: DW_A] = m_mem[ra * RATIO + i];
            end
            e.cyc = cyc + 1;
            rd_q.push_back(e);
        end
        if (rs) begin
            m_busy = 0; m_done = 0; m_wrapped = 0; m_circ = 0;
            m_ptr = 0; m_count = 0; m_len = 0;
        end else if (a) begin
            m_len = (ln == 0 || ln > DEPTH) ? DEPTH : ln;
            m_circ = c; m_busy = 1; m_done = 0; m_wrapped = 0; m_ptr = 0; m_count = 0;
        end else if (m_busy) begin
            if (dv) begin
                m_mem[m_ptr] = d;
                if (m_count < m_len) m_count++;
                if (m_circ) begin
                    m_ptr = (m_ptr + 1) % m_len;
                    if (m_ptr == 0) m_wrapped = 1;
                end else begin
                    m_ptr = (m_ptr + 1) % DEPTH;
                    if (m_count == m_len) begin m_busy = 0; m_done = 1; end
                end
            end
            if (m_circ && s) begin m_busy = 0; m_done = 1; end
        end
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("wrapped", 64'(wrapped), 64'(m_wrapped));
        chk("wr_ptr", 64'(wr_ptr), 64'(m_ptr));
        chk("wr_count", 64'(wr_count), 64'(m_count));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] d);
        step(0, 0, 0, 0, d, 1, 0, 0, 0);
    endtask

    task automatic rd(input int unsigned ra);
        step(0, 0, 0, 0, 0, 0, 1, ra, 0);
    endtask

    task automatic do_reset(input bit dv);
        for (int i = 0; i < int'(LAT); i++) idle();
        step(0, 0, 0, 0, 32'hdead0000, dv, 0, 0, 1);
    endtask

    initial begin
        int unsigned r_len_sel;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = INIT;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_dout_valid", 64'(dout_valid), 64'd0);
        chk("reset_dout_low", dout[63:0], 64'd0);
        mon_en = 1'b1;

        // Power-up read of untouched memory.
        rd(0);
        idle(); idle();

        // Reset mid-capture after 7 writes; the write on the reset cycle is dropped.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) wr(32'(200 + k));
        do_reset(1);
        rd(0);
        idle(); idle();

        // One-shot, len 32, din = index.
        step(1, 0, 0, 32, 0, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) wr(32'(k));
        chk("oneshot_done", 64'(done), 64'd1);
        chk("oneshot_count", 64'(wr_count), 64'd32);
        rd(0); rd(1);
        idle(); idle();

        // Circular, len 16, 20 samples.
        step(1, 0, 1, 16, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) wr(32'(k));
        chk("circ_wrapped", 64'(wrapped), 64'd1);
        chk("circ_ptr", 64'(wr_ptr), 64'd4);
        rd(0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("circ_stop_done", 64'(done), 64'd1);

        // Gapped writes with a same-cycle arm+stop restart.
        step(1, 0, 1, 64, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step(k == 6, k == 6, 1, 64, 32'(100 + k), k % 2 == 0, 0, 0, 0);
        end
        rd(0);
        idle(); idle();

        // Same-edge read/write on lane 3 of raddr 0.
        step(1, 0, 0, 8, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) wr(32'(300 + k));
        step(0, 0, 0, 0, 32'h0bad0003, 1, 1, 0, 0);
        rd(0);
        idle(); idle();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                r_len_sel = $urandom_range(0, 9);
                step($urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
                     $urandom_range(0, 1) == 1,
                     (r_len_sel == 0) ? 0 : (r_len_sel == 1) ? 20000 : $urandom_range(1, 80),
                     $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 6), 0);
            end
        end

        for (int i = 0; i < int'(LAT) + 2; i++) idle();
        chk("read_queue_empty", 64'(rd_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
